wb_sram_ctrl: RTL

Wishbone classic single-access slave that sits directly downstream of the bus arbiter. It converts each granted cyc/stb cycle into a timed read or write on an external asynchronous SRAM, with programmable wait states. It returns a one-cycle ack and latched read data.

---
 rtl/wb_sram_ctrl_pkg.sv | 30 +++
 rtl/wb_sram_ctrl_if.sv | 23 ++
 rtl/wb_sram_ctrl_wait_counter.sv | 28 ++
 rtl/wb_sram_ctrl.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/wb_sram_ctrl_pkg.sv
// Shared Wishbone-side definitions: FSM encoding, wait-counter width and the byte-to-word address shift.
// TURN exists only when WB_SRAM_TURNAROUND_EN is defined.
package wb_pkg;

    localparam int WAIT_CNT_WIDTH = 4;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_READ  = 3'd1;
    localparam logic [2:0] ST_WRITE = 3'd2;
    localparam logic [2:0] ST_ACK   = 3'd3;
`ifdef WB_SRAM_TURNAROUND_EN
    localparam logic [2:0] ST_TURN  = 3'd4;
`endif

    typedef enum logic [2:0] {
        IDLE  = ST_IDLE,
        READ  = ST_READ,
        WRITE = ST_WRITE,
        ACK   = ST_ACK
`ifdef WB_SRAM_TURNAROUND_EN
        , TURN = ST_TURN
`endif
    } state_t;

    // Number of byte-address bits below the SRAM word address.
    function automatic int addrLsb(input int dataWidth);
        return $clog2(dataWidth / 8);
    endfunction

endpackage

// File: rtl/wb_sram_ctrl_if.sv
// Wishbone classic single-access bus between the arbiter (master) and an SRAM controller (slave).
interface wb_sram_ctrl_if #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32
);
    logic                     cycI;
    logic                     stbI;
    logic                     weI;
    logic                     ackO;
    logic [ADDRESS_WIDTH-1:0] adrI;
    logic [DATA_WIDTH-1:0]    datI;
    logic [DATA_WIDTH-1:0]    datO;

    modport master (
        output cycI, stbI, weI, adrI, datI,
        input  ackO, datO
    );

    modport slave (
        input  cycI, stbI, weI, adrI, datI,
        output ackO, datO
    );
endinterface

// File: rtl/wb_sram_ctrl_wait_counter.sv
// Loadable down-counter with a zero flag; times strobe widths for external memory controllers.
module sram_wait_counter
    import wb_pkg::*;
(
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic                      i_load,
    input  logic [WAIT_CNT_WIDTH-1:0] i_loadValue,
    input  logic                      i_dec,
    output logic                      o_zero
);

    logic [WAIT_CNT_WIDTH-1:0] r_count;

    // Decrement saturates at zero so a late i_dec cannot wrap the count.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_loadValue;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_zero = (r_count == '0);

endmodule

// File: rtl/wb_sram_ctrl.sv
// Wishbone classic slave driving an asynchronous SRAM with programmable read/write strobe widths.
// Optional WB_SRAM_TURNAROUND_EN inserts one dead cycle after each read for bus turnaround.
module wb_sram_ctrl
    import wb_pkg::*;
#(
    parameter int ADDRESS_WIDTH   = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int SRAM_ADDR_WIDTH = 18,
    parameter int READ_WAIT       = 2,
    parameter int WRITE_WAIT      = 2
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    wb_sram_ctrl_if.slave              io_wb,
    output logic [SRAM_ADDR_WIDTH-1:0] o_sramAddr,
    input  logic [DATA_WIDTH-1:0]      i_sramDqI,
    output logic [DATA_WIDTH-1:0]      o_sramDqO,
    output logic                       o_sramDqOe,
    output logic                       o_sramCeN,
    output logic                       o_sramOeN,
    output logic                       o_sramWeN
);

    localparam int ADDR_LSB = addrLsb(DATA_WIDTH);
    localparam logic [WAIT_CNT_WIDTH-1:0] READ_LOAD  = WAIT_CNT_WIDTH'(READ_WAIT);
    localparam logic [WAIT_CNT_WIDTH-1:0] WRITE_LOAD = WAIT_CNT_WIDTH'(WRITE_WAIT);

    state_t                      r_state;
    state_t                      w_nextState;
    logic                        r_isWrite;
    logic [SRAM_ADDR_WIDTH-1:0]  r_sramAddr;
    logic [DATA_WIDTH-1:0]       r_sramDqO;
    logic [DATA_WIDTH-1:0]       r_datO;
    logic [ADDRESS_WIDTH-1:0]    w_adr;
    logic                        w_req;
    logic                        w_load;
    logic [WAIT_CNT_WIDTH-1:0]   w_loadValue;
    logic                        w_dec;
    logic                        w_cntZero;
    logic                        w_ack;

    assign w_adr = io_wb.adrI;
    assign w_req = io_wb.cycI & io_wb.stbI;

    sram_wait_counter u_waitCounter (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_load      (w_load),
        .i_loadValue (w_loadValue),
        .i_dec       (w_dec),
        .o_zero      (w_cntZero)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Strobes decode from registered state so an async reset drops them at once.
    always_comb begin
        w_nextState = r_state;
        w_load      = 1'b0;
        w_loadValue = READ_LOAD;
        w_dec       = 1'b0;
        w_ack       = 1'b0;
        o_sramCeN   = 1'b1;
        o_sramOeN   = 1'b1;
        o_sramWeN   = 1'b1;
        o_sramDqOe  = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_req) begin
                    w_load      = 1'b1;
                    w_loadValue = io_wb.weI ? WRITE_LOAD : READ_LOAD;
                    w_nextState = io_wb.weI ? WRITE : READ;
                end
            end
            READ: begin
                o_sramCeN = 1'b0;
                o_sramOeN = 1'b0;
                w_dec     = 1'b1;
                if (w_cntZero) begin
                    w_nextState = ACK;
                end
            end
            WRITE: begin
                o_sramCeN  = 1'b0;
                o_sramWeN  = 1'b0;
                o_sramDqOe = 1'b1;
                w_dec      = 1'b1;
                if (w_cntZero) begin
                    w_nextState = ACK;
                end
            end
            ACK: begin
                // Writes keep CE and the pads through ACK for data hold time.
                o_sramCeN  = ~r_isWrite;
                o_sramDqOe = r_isWrite;
                w_ack      = w_req;
`ifdef WB_SRAM_TURNAROUND_EN
                w_nextState = r_isWrite ? IDLE : TURN;
`else
                w_nextState = IDLE;
`endif
            end
`ifdef WB_SRAM_TURNAROUND_EN
            TURN: begin
                w_nextState = IDLE;
            end
`endif
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sramAddr <= '0;
            r_sramDqO  <= '0;
            r_datO     <= '0;
            r_isWrite  <= 1'b0;
        end else begin
            if (w_load) begin
                r_sramAddr <= w_adr[ADDR_LSB +: SRAM_ADDR_WIDTH];
                r_sramDqO  <= io_wb.datI;
                r_isWrite  <= io_wb.weI;
            end
            if ((r_state == READ) && w_cntZero) begin
                r_datO <= i_sramDqI;
            end
        end
    end

    assign o_sramAddr = r_sramAddr;
    assign o_sramDqO  = r_sramDqO;
    assign io_wb.ackO = w_ack;
    assign io_wb.datO = r_datO;

endmodule
